// File: rtl/nop_pkg.sv
// Shared definitions for the NOP stall unit: state encoding and default widths.
package nop_pkg;

    typedef enum logic [1:0] {
        NOP_IDLE = 2'd0,
        NOP_WAIT = 2'd1,
        NOP_DONE = 2'd2
    } nop_state_t;

    localparam int unsigned NOP_DATA_W = 20;
    localparam int unsigned NOP_CNT_W  = 8;
    localparam int unsigned NOP_RET_W  = 16;

endpackage

// File: rtl/nop_cycle_counter.sv
// Loadable down-counter that times the WAIT phase of a NOP.
module nop_cycle_counter
    import nop_pkg::*;
#(
    parameter int unsigned CNT_W = NOP_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] value,
    output logic             is_one
);

    always_ff @(posedge clk) begin
        if (reset) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (en) begin
            value <= value - CNT_W'(1);
        end
    end

    assign is_one = (value == CNT_W'(1));

endmodule

// File: rtl/nop_delay.sv
// Multi-cycle NOP unit: captures an operand, stalls a programmed number of
// cycles, then returns the operand with a one-cycle done pulse.
module nop_delay
    import nop_pkg::*;
#(
    parameter int unsigned DATA_W = NOP_DATA_W,
    parameter int unsigned CNT_W  = NOP_CNT_W,
    parameter int unsigned RET_W  = NOP_RET_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [CNT_W-1:0]  cycles,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic [RET_W-1:0]  retired
);

    nop_state_t        state;
    logic [DATA_W-1:0] data_latch;
    logic [CNT_W-1:0]  count_value;
    logic              count_is_one;
    logic              accept;
    logic              short_nop;
    logic              count_load;
    logic              count_en;

    always_comb begin
        accept     = (state != NOP_WAIT) && start && !flush;
        short_nop  = (cycles <= CNT_W'(1));
        count_load = accept && !short_nop;
        count_en   = (state == NOP_WAIT) && !flush && (count_value > CNT_W'(1));
    end

    // WAIT lasts N-1 cycles, so the counter is loaded with N-1 and DONE
    // follows the cycle in which it reads one; N<=1 skips WAIT entirely.
    nop_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (count_load),
        .en         (count_en),
        .load_value (cycles - CNT_W'(1)),
        .value      (count_value),
        .is_one     (count_is_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= NOP_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            retired    <= '0;
            data_latch <= '0;
        end else begin
            case (state)
                NOP_IDLE, NOP_DONE: begin
                    if (accept) begin
                        data_latch <= data;
                        if (short_nop) begin
                            state   <= NOP_DONE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            result  <= data;
                            retired <= retired + RET_W'(1);
                        end else begin
                            state <= NOP_WAIT;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end else begin
                        state <= NOP_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                NOP_WAIT: begin
                    if (flush) begin
                        state <= NOP_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (count_is_one) begin
                        state   <= NOP_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        result  <= data_latch;
                        retired <= retired + RET_W'(1);
                    end
                end
                default: begin
                    state <= NOP_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nop_delay.sv
// Directed-vector bench for nop_delay with hand-computed expected values.
module tb_nop_delay;

    localparam int unsigned DATA_W = 20;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned RET_W  = 4;

    logic              clk;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cycles;
    logic              flush;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [RET_W-1:0]  retired;

    int checks;
    int failures;

    nop_delay #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .RET_W  (RET_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data    (data),
        .cycles  (cycles),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .retired (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic b, input logic d,
                              input logic [31:0] r, input logic [31:0] ret);
        check({tag, ".busy"}, 32'(busy), 32'(b));
        check({tag, ".done"}, 32'(done), 32'(d));
        check({tag, ".result"}, 32'(result), r);
        check({tag, ".retired"}, 32'(retired), ret);
    endtask

    initial begin
        int lat;
        int nbusy;
        int done_seen;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        data     = '0;
        cycles   = '0;

        tick();
        tick();
        check_outs("reset", 1'b0, 1'b0, 32'h0, 32'd0);
        reset = 1'b0;

        // N=3: busy two cycles, done on the third
        start = 1'b1; data = 20'h12345; cycles = 8'd3;
        tick();
        check_outs("n3_c1", 1'b1, 1'b0, 32'h0, 32'd0);
        start = 1'b0;
        tick();
        check_outs("n3_c2", 1'b1, 1'b0, 32'h0, 32'd0);
        tick();
        check_outs("n3_c3", 1'b0, 1'b1, 32'h12345, 32'd1);
        tick();
        check_outs("n3_idle", 1'b0, 1'b0, 32'h12345, 32'd1);

        // N=0 then N=1 back to back
        start = 1'b1; data = 20'hABCDE; cycles = 8'd0;
        tick();
        check_outs("n0", 1'b0, 1'b1, 32'hABCDE, 32'd2);
        data = 20'h00001; cycles = 8'd1;
        tick();
        check_outs("n1", 1'b0, 1'b1, 32'h00001, 32'd3);
        start = 1'b0;
        tick();
        check_outs("n1_idle", 1'b0, 1'b0, 32'h00001, 32'd3);

        // flush in WAIT, with a competing start that must be ignored
        start = 1'b1; data = 20'h11111; cycles = 8'd5;
        tick();
        check_outs("fw_c1", 1'b1, 1'b0, 32'h00001, 32'd3);
        start = 1'b0;
        tick();
        check_outs("fw_c2", 1'b1, 1'b0, 32'h00001, 32'd3);
        flush = 1'b1; start = 1'b1; data = 20'h99999; cycles = 8'd0;
        tick();
        check_outs("fw_flush", 1'b0, 1'b0, 32'h00001, 32'd3);
        flush = 1'b0; start = 1'b1; data = 20'h22222; cycles = 8'd0;
        tick();
        check_outs("fw_next", 1'b0, 1'b1, 32'h22222, 32'd4);

        // flush in DONE: completed NOP stays counted, new start rejected
        data = 20'h33333;
        tick();
        check_outs("fd_done", 1'b0, 1'b1, 32'h33333, 32'd5);
        flush = 1'b1; data = 20'h44444;
        tick();
        check_outs("fd_flush", 1'b0, 1'b0, 32'h33333, 32'd5);

        // flush in IDLE swallows start
        data = 20'h55555;
        tick();
        check_outs("fi", 1'b0, 1'b0, 32'h33333, 32'd5);
        flush = 1'b0; start = 1'b0;
        tick();

        // start held with N=0: a done every cycle
        start = 1'b1; cycles = 8'd0;
        data = 20'h00010;
        tick();
        check_outs("hold0", 1'b0, 1'b1, 32'h00010, 32'd6);
        data = 20'h00011;
        tick();
        check_outs("hold1", 1'b0, 1'b1, 32'h00011, 32'd7);
        data = 20'h00012;
        tick();
        check_outs("hold2", 1'b0, 1'b1, 32'h00012, 32'd8);
        data = 20'h00013;
        tick();
        check_outs("hold3", 1'b0, 1'b1, 32'h00013, 32'd9);
        start = 1'b0;
        tick();
        check_outs("hold_end", 1'b0, 1'b0, 32'h00013, 32'd9);

        // maximum stall N=255
        start = 1'b1; data = 20'h0FFFF; cycles = 8'd255;
        tick();
        start = 1'b0;
        lat = 1; nbusy = 0; done_seen = 0;
        while (!done && lat < 300) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        if (done) done_seen = 1;
        check("n255.done_seen", 32'(done_seen), 32'd1);
        check("n255.latency", 32'(lat), 32'd255);
        check("n255.busy_cycles", 32'(nbusy), 32'd254);
        check("n255.result", 32'(result), 32'h0FFFF);
        check("n255.retired", 32'(retired), 32'd10);
        tick();

        // six more completions: retired goes 11..15 then wraps to 0
        start = 1'b1; cycles = 8'd0; data = 20'h00ABC;
        for (int i = 0; i < 5; i++) tick();
        check("wrap.pre", 32'(retired), 32'd15);
        tick();
        check("wrap.zero", 32'(retired), 32'd0);
        check("wrap.done", 32'(done), 32'd1);
        start = 1'b0;
        tick();

        // reset during WAIT
        start = 1'b1; data = 20'h77777; cycles = 8'd10;
        tick();
        check_outs("rw_c1", 1'b0 | 1'b1, 1'b0, 32'h00ABC, 32'd0);
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_outs("rw_reset", 1'b0, 1'b0, 32'h0, 32'd0);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) done_seen = 1;
        end
        check("rw.no_done", 32'(done_seen), 32'd0);

        // counter reloads cleanly after reset: N=2
        start = 1'b1; data = 20'h00005; cycles = 8'd2;
        tick();
        check_outs("post_c1", 1'b1, 1'b0, 32'h0, 32'd0);
        start = 1'b0;
        tick();
        check_outs("post_c2", 1'b0, 1'b1, 32'h00005, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
